// File: rtl/gf193_reduce_seq.sv
// gf193_reduce_seq
// Sequential reduction of a 385-bit GF(2)[x] product modulo
// F(x) = x^193 + x^15 + 1. D product bits are folded per cycle, from the top
// of the accumulator downward. The latency is fixed at NF = ceil(192/D) fold
// cycles, whatever the data.
//
// Ports
//   clk       : clock; all state changes on the rising edge
//   rst       : synchronous active-high reset
//   y_in      : [384:0] unreduced product; bit i is the coefficient of x^i
//   in_valid  : y_in is presented
//   in_ready  : the block accepts y_in this cycle (IDLE only)
//   r_out     : [192:0] registered result, y_in mod F(x)
//   out_valid : r_out holds a result (DONE only)
//   out_ready : the consumer takes r_out
module gf193_reduce_seq #(
  parameter int D = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [384:0] y_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [192:0] r_out,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int NF = (192 + D - 1) / D;
  localparam int CW = $clog2(NF + 1);
  localparam logic [CW-1:0] LAST = CW'(NF - 1);

  typedef enum logic [1:0] {IDLE, FOLD, DONE} state_t;

  state_t        state, state_nxt;
  logic [384:0]  acc, acc_fold;
  logic [CW-1:0] cnt;
  logic          last;
  int            k;

  assign last = (cnt == LAST);

  // One fold step. Window k covers bits 384-k*D down to max(193, 385-(k+1)*D).
  // Every set bit i in the window is replaced by x^(i-193) + x^(i-178).
  // Because D <= 178, i-178 always lands below the window. Within one step
  // no target bit therefore sits inside the window, and reading acc (the
  // value at cycle start) gives the same result as a serial fold.
  always_comb begin
    k        = 32'(cnt);
    acc_fold = acc;
    for (int i = 193; i < 385; i++) begin
      if ((i + (k + 1) * D >= 385) && (i + k * D <= 384) && acc[i]) begin
        acc_fold[i]       = 1'b0;
        acc_fold[i - 193] = acc_fold[i - 193] ^ 1'b1;
        acc_fold[i - 178] = acc_fold[i - 178] ^ 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = FOLD;
      FOLD:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: accumulator, fold counter, result register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      r_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc <= y_in;
            cnt <= '0;
          end
        end
        FOLD: begin
          acc <= acc_fold;
          cnt <= cnt + CW'(1);
          if (last) r_out <= acc_fold[192:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/gf193_reduce_seq.md
GF193_REDUCE_SEQ -- requirements
Module: gf193_reduce_seq

Interface
REQ-001 The block SHALL have parameter D, default 16, meaning the number of product bits folded per cycle; legal values are 1..178.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset; synchronous and active-high.
REQ-004 The block SHALL have port y_in, input, 385 bits: the unreduced GF(2)[x] product of two 193-bit operands; bit i is the coefficient of x^i.
REQ-005 The block SHALL have port in_valid, input, 1 bit: y_in is presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts y_in this cycle.
REQ-007 The block SHALL have port r_out, output, 193 bits: y_in mod F(x), where F(x) = x^193 + x^15 + 1.
REQ-008 The block SHALL have port out_valid, output, 1 bit: r_out holds a result.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the downstream consumer takes r_out.

Function
REQ-010 The block SHALL implement FSM states IDLE, FOLD and DONE.
- in_ready = 1 only in IDLE.
- out_valid = 1 only in DONE.
REQ-011 In IDLE, when in_valid = 1, the block SHALL load the 385-bit accumulator acc with y_in, clear the cycle counter cnt, and enter FOLD on that edge.
REQ-012 In IDLE, when in_valid = 0, the block SHALL hold its state.
REQ-013 The fold count SHALL be NF = ceil(192/D); for D = 16, NF = 12.
REQ-014 In FOLD cycle k (k = cnt, 0..NF-1), the block SHALL process the window of acc bits from 384-k*D down to max(193, 385-(k+1)*D).
- Each set bit i in the window is cleared.
- x^(i-193) and x^(i-178) are XORed into acc.
- All window bits are folded in one cycle, using window contents sampled at cycle start.
REQ-015 Folds SHALL descend strictly, so that bits landing at positions 193..206 fall in later windows; D <= 178 guarantees this, and D > 178 is unsupported.
REQ-016 On the edge of FOLD cycle NF-1, the block SHALL enter DONE with acc[384:193] = 0.
REQ-017 r_out SHALL equal acc[192:0] and be registered.
REQ-018 Latency SHALL be fixed and data-independent: out_valid rises exactly NF edges after the accepting edge (12 for D = 16).
REQ-019 In DONE, the block SHALL hold out_valid and r_out stable while out_ready = 0.
REQ-020 In DONE, when out_ready = 1, the block SHALL return to IDLE on that edge; in_ready is then 1 on the following cycle.
REQ-021 When in DONE or FOLD, the block SHALL not accept in_valid or y_in and SHALL leave state unaffected; no input overlap exists, and throughput is one result per NF+2 cycles minimum.
REQ-022 When y_in[384:193] = 0, the block SHALL still run all NF folds, and r_out = y_in[192:0].
REQ-023 When out_ready is already high on entry to DONE, the block SHALL spend exactly one cycle in DONE.
REQ-024 The block SHALL implement the fold as a pure XOR network, with no carries; cnt width is ceil(log2(NF+1)).

Reset
REQ-025 When rst = 1 at a rising edge, the block SHALL force the state to IDLE, acc = 0, cnt = 0, r_out = 0, out_valid = 0 and in_ready = 1 after that edge; this has priority over all other inputs.
REQ-026 A reset asserted during FOLD or DONE SHALL discard the operation in flight, and no out_valid pulse SHALL follow for it.
REQ-027 After reset deassertion, the first accept SHALL be possible on the first edge with in_valid = 1.

Verification (D = 16 unless noted)
REQ-028 The bench SHALL cover: y_in = x^193 (bit 193 only) -> r_out = 0x8001 (x^15 + 1), out_valid 12 edges after accept.
REQ-029 The bench SHALL cover: y_in = x^384 -> r_out = x^191 + x^28 + x^13 (bits 191, 28 and 13 set only), covering the double fold through bits 193..206.
REQ-030 The bench SHALL cover: y_in = 0x1234 (no high bits) -> r_out = 0x1234, latency still 12.
REQ-031 The bench SHALL cover: out_ready held low for 5 cycles in DONE with in_valid = 1 and y_in changing -> r_out and out_valid stable, in_ready = 0, no new accept; out_ready = 1 -> IDLE on the next edge.
REQ-032 The bench SHALL cover: rst pulsed at FOLD cycle 5 -> next cycle out_valid = 0, in_ready = 1, r_out = 0; a subsequent x^193 input yields 0x8001.
REQ-033 The bench SHALL cover 1000 random 385-bit y_in for each of D in {1, 16, 64, 178} -> r_out equals the software GF(2^193) model mod F(x), with latency NF = 192, 12, 3 and 2 respectively.
